// File: rtl/frame_request_arbiter.sv
`default_nettype none
// ============================================================================
// frame_request_arbiter : round-robin arbiter for per-console next-frame fetches
// Optional macro FRAME_ARB_LOCKSTEP_EN : fetch only when all consoles request.
// Revision: 1.0
// ============================================================================
module frame_request_arbiter #(
   parameter int NUM_CONSOLES   = 1,
   parameter int IDX_W          = 6,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CONSOLES-1:0] request_frame,
   output logic                    fetch_req,
   output logic [IDX_W-1:0]        fetch_idx,
   input  logic                    fetch_ack,
   input  logic                    frame_wr_en,
   output logic [NUM_CONSOLES-1:0] console_wr_en,
   output logic                    busy,
   output logic                    timeout
);

   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t                  state;
   logic [NUM_CONSOLES-1:0] req_q;
   logic [NUM_CONSOLES-1:0] pending;
   logic [TMR_W-1:0]        timer;

   logic [NUM_CONSOLES-1:0] rise;
   logic [NUM_CONSOLES-1:0] pend_clr;
   logic [NUM_CONSOLES-1:0] pend_set;
   logic [IDX_W-1:0]        grant_idx;
   logic                    issue;
   logic                    done;
   logic                    expire;
   logic                    fwd;

   assign rise   = request_frame & ~req_q;
   assign done   = (state == S_WAIT) && frame_wr_en;
   // A completing write in the expiry cycle beats the timeout
   assign expire = (state != S_IDLE) && (timer == TMR_LAST) && !done;
   assign fwd    = frame_wr_en && ((state == S_WAIT) || ((state == S_REQ) && fetch_ack));

`ifdef FRAME_ARB_LOCKSTEP_EN
   assign issue         = &pending;
   assign grant_idx     = '0;
   assign pend_clr      = done   ? '1 : '0;
   assign pend_set      = expire ? '1 : '0;
   assign console_wr_en = fwd    ? '1 : '0;
`else
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CONSOLES - 1);

   logic [IDX_W-1:0]        ptr;
   logic [IDX_W-1:0]        ptr_next;
   logic [NUM_CONSOLES-1:0] rot;
   logic [NUM_CONSOLES-1:0] grant_hot;
   logic [NUM_CONSOLES-1:0] cur_hot;
   logic                    rr_hit;

   // Rotate so bit 0 is the console at the pointer; first set bit wins
   assign rot = (pending >> ptr) | (pending << (NUM_CONSOLES - int'(ptr)));

   always_comb begin
      rr_hit    = 1'b0;
      grant_idx = '0;
      for (int off = 0; off < NUM_CONSOLES; off++) begin
         if (!rr_hit && rot[off]) begin
            rr_hit = 1'b1;
            if (int'(ptr) + off >= NUM_CONSOLES)
               grant_idx = ptr + IDX_W'(off) - IDX_W'(NUM_CONSOLES);
            else
               grant_idx = ptr + IDX_W'(off);
         end
      end
   end

   always_comb begin
      grant_hot = '0;
      cur_hot   = '0;
      for (int i = 0; i < NUM_CONSOLES; i++) begin
         grant_hot[i] = (grant_idx == IDX_W'(i));
         cur_hot[i]   = (fetch_idx == IDX_W'(i));
      end
   end

   assign issue         = rr_hit;
   assign ptr_next      = (fetch_idx == IDX_LAST) ? '0 : fetch_idx + IDX_W'(1);
   assign pend_clr      = ((state == S_IDLE) && issue) ? grant_hot : '0;
   assign pend_set      = expire ? cur_hot : '0;
   assign console_wr_en = fwd ? cur_hot : '0;

   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (done || expire)
         ptr <= ptr_next;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         req_q     <= request_frame;
         pending   <= '0;
         timer     <= '0;
         fetch_req <= 1'b0;
         fetch_idx <= '0;
         busy      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         req_q   <= request_frame;
         timeout <= 1'b0;
         // New edges and retries take precedence over the grant clear
         pending <= (pending & ~pend_clr) | rise | pend_set;
         case (state)
            S_IDLE: begin
               if (issue) begin
                  fetch_idx <= grant_idx;
                  fetch_req <= 1'b1;
                  busy      <= 1'b1;
                  state     <= S_REQ;
               end
            end
            S_REQ: begin
               if (expire) begin
                  fetch_req <= 1'b0;
                  busy      <= 1'b0;
                  timeout   <= 1'b1;
                  timer     <= '0;
                  state     <= S_IDLE;
               end else begin
                  timer <= timer + TMR_W'(1);
                  if (fetch_ack) begin
                     fetch_req <= 1'b0;
                     state     <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (done || expire) begin
                  busy    <= 1'b0;
                  timeout <= expire;
                  timer   <= '0;
                  state   <= S_IDLE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
